// File: rtl/clk_pattern_pkg.sv
// Shared types and constants for the clock-pattern controller.
// Channel state encoding, index width and reset config.
package clk_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CH_W     = 2;
  localparam int RST_HIGH = 1;
  localparam int RST_LOW  = 1;

endpackage

// File: rtl/clk_pattern_chan.sv
// One pattern channel: phase FSM, down-counter, active and
// shadow config with a pending flag.
module clk_pattern_chan
  import clk_pattern_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_high,
  input  logic [CNT_W-1:0] ld_low,
  output logic             pat,
  output logic             start,
  output logic             busy,
  output logic             pending
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] low;
  logic [CNT_W-1:0] sh_high;
  logic [CNT_W-1:0] sh_low;
  logic [CNT_W-1:0] nxt_high;

  // High time of the next period once any shadow is promoted.
  always_comb nxt_high = pending ? sh_high : high;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      high    <= CNT_W'(RST_HIGH);
      low     <= CNT_W'(RST_LOW);
      sh_high <= '0;
      sh_low  <= '0;
      pending <= 1'b0;
      pat     <= 1'b0;
      start   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state <= HIGH;
            cnt   <= high - 1'b1;
            pat   <= 1'b1;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            state <= LOW;
            cnt   <= low - 1'b1;
            pat   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            if (pending) begin
              high    <= sh_high;
              low     <= sh_low;
              pending <= 1'b0;
            end
            if (run) begin
              state <= HIGH;
              cnt   <= nxt_high - 1'b1;
              pat   <= 1'b1;
              start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pat   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      // ld is only granted while pending is clear, so it never
      // races the shadow promotion above.
      if (ld) begin
        if (state == IDLE) begin
          high <= ld_high;
          low  <= ld_low;
        end else begin
          sh_high <= ld_high;
          sh_low  <= ld_low;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_pattern_ctrl.sv
// Multi-channel periodic pattern generator with a
// valid/ready config port and per-channel shadowing.
module clk_pattern_ctrl
  import clk_pattern_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] run_en,
  output logic [NUM_CH-1:0] pat_out,
  output logic [NUM_CH-1:0] period_start,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] pending;
  logic [3:0]        pend4;
  logic              ch_ok;
  logic              xfer;
  logic              bad;
  logic              load;

  always_comb begin
    pend4             = '0;
    pend4[NUM_CH-1:0] = pending;
  end

  assign ch_ok     = 32'(cfg_ch) < 32'(NUM_CH);
  assign cfg_ready = ch_ok ? !pend4[cfg_ch] : 1'b1;
  assign xfer      = cfg_valid && cfg_ready;
  assign bad       = !ch_ok || (cfg_high == '0) || (cfg_low == '0);
  assign load      = xfer && !bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && bad;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_pattern_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .run    (run_en[i]),
      .ld     (load && (cfg_ch == CH_W'(i))),
      .ld_high(cfg_high),
      .ld_low (cfg_low),
      .pat    (pat_out[i]),
      .start  (period_start[i]),
      .busy   (busy[i]),
      .pending(pending[i])
    );
  end

endmodule

// File: tb/tb_clk_pattern_ctrl.sv
// Directed bench for clk_pattern_ctrl: defaults, loads,
// shadowing, errors, graceful stop, collision and reset.
module tb_clk_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_high = '0;
  logic [7:0] cfg_low = '0;
  logic       cfg_err;
  logic [2:0] run_en = '0;
  logic [2:0] pat_out;
  logic [2:0] period_start;
  logic [2:0] busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_pattern_ctrl #(
    .NUM_CH(3),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .cfg_err     (cfg_err),
    .run_en      (run_en),
    .pat_out     (pat_out),
    .period_start(period_start),
    .busy        (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch,
                     input logic [7:0] h,
                     input logic [7:0] l);
    cfg_ch    = ch;
    cfg_high  = h;
    cfg_low   = l;
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
  endtask

  logic       p;
  logic       s;

  initial begin
    // reset defaults: 1/1 on all channels
    tick;
    tick;
    chk("rst_pat", pat_out, 3'b000);
    chk("rst_start", period_start, 3'b000);
    chk("rst_busy", busy, 3'b000);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    rst    = 1'b0;
    run_en = 3'b111;
    for (int t = 0; t <= 6; t++) begin
      tick;
      if (t < 6) begin
        chk("dflt_pat", pat_out, (t % 2 == 0) ? 3'b111 : 3'b000);
        chk("dflt_start", period_start,
            (t % 2 == 0) ? 3'b111 : 3'b000);
      end else begin
        chk("dflt_stop", busy, 3'b000);
      end
      if (t == 5) run_en = 3'b000;
    end

    // IDLE load on ch2: 3 high / 7 low
    cfg(2'd2, 8'd3, 8'd7);
    run_en = 3'b100;
    for (int t = 0; t <= 20; t++) begin
      tick;
      if (t < 20) begin
        p = (t % 10) < 3;
        s = (t % 10) == 0;
        chk("idle_pat", pat_out, {p, 2'b00});
        chk("idle_start", period_start, {s, 2'b00});
        chk("idle_busy", busy, 3'b100);
      end else begin
        chk("idle_stop", busy, 3'b000);
      end
      if (t == 19) run_en = 3'b000;
    end

    // shadow config on ch0: 2/2 then 4/1
    cfg(2'd0, 8'd2, 8'd2);
    run_en = 3'b001;
    for (int t = 0; t <= 14; t++) begin
      tick;
      cfg_valid = 1'b0;
      if (t <= 13) begin
        p = (t < 4) ? ((t % 4) < 2) : (((t - 4) % 5) < 4);
        s = (t == 0) || (t >= 4 && ((t - 4) % 5) == 0);
        chk("shd_pat", pat_out, {2'b00, p});
        chk("shd_start", period_start, {2'b00, s});
      end else begin
        chk("shd_stop", busy, 3'b000);
      end
      if (t == 0) begin
        cfg_ch   = 2'd0;
        cfg_high = 8'd4;
        cfg_low  = 8'd1;
        chk("shd_ready_free", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
      end
      if (t == 1) begin
        chk("shd_ready_pend", cfg_ready, 1'b0);
        cfg_high  = 8'd7;
        cfg_low   = 8'd7;
        cfg_valid = 1'b1;
      end
      if (t == 2) chk("shd_no_err", cfg_err, 1'b0);
      if (t == 13) run_en = 3'b000;
    end

    // error handling
    cfg(2'd1, 8'd0, 8'd5);
    chk("err_zero_h", cfg_err, 1'b1);
    tick;
    chk("err_clear", cfg_err, 1'b0);
    cfg_ch = 2'd3;
    #1;
    chk("err_ch3_ready", cfg_ready, 1'b1);
    cfg(2'd3, 8'd2, 8'd2);
    chk("err_bad_ch", cfg_err, 1'b1);
    run_en = 3'b010;
    for (int t = 0; t <= 4; t++) begin
      tick;
      p = (t <= 2) && (t % 2 == 0);
      chk("err_ch1_pat", pat_out, {1'b0, p, 1'b0});
      chk("err_ch1_busy", busy, {1'b0, (t <= 3), 1'b0});
      if (t == 2) run_en = 3'b000;
    end

    // graceful stop on ch0 with 5/5
    cfg(2'd0, 8'd5, 8'd5);
    run_en = 3'b001;
    for (int t = 0; t <= 12; t++) begin
      tick;
      chk("stop_pat", pat_out, {2'b00, (t <= 4)});
      chk("stop_busy", busy, {2'b00, (t <= 9)});
      chk("stop_start", period_start, {2'b00, (t == 0)});
      if (t == 1) run_en = 3'b000;
    end

    // boundary collision, then reset mid-HIGH with a pending config
    cfg(2'd2, 8'd2, 8'd1);
    run_en = 3'b100;
    for (int t = 0; t <= 12; t++) begin
      tick;
      cfg_valid = 1'b0;
      if (t < 6) begin
        p = (t % 3) < 2;
        s = (t % 3) == 0;
      end else if (t < 10) begin
        p = ((t - 6) % 4) == 0;
        s = p;
      end else begin
        p = ((t - 10) % 6) < 3;
        s = ((t - 10) % 6) == 0;
      end
      chk("col_pat", pat_out, {p, 2'b00});
      chk("col_start", period_start, {s, 2'b00});
      cfg_ch = 2'd2;
      if (t == 2 || t == 6 || t == 11) begin
        chk("col_ready", cfg_ready, 1'b1);
        cfg_high  = (t == 2) ? 8'd1 : (t == 6) ? 8'd3 : 8'd5;
        cfg_low   = (t == 2) ? 8'd3 : (t == 6) ? 8'd3 : 8'd5;
        cfg_valid = 1'b1;
      end
      if (t == 3) chk("col_ready_pend", cfg_ready, 1'b0);
      if (t == 12) rst = 1'b1;
    end
    tick;
    chk("mrst_pat", pat_out, 3'b000);
    chk("mrst_busy", busy, 3'b000);
    chk("mrst_start", period_start, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1;
      chk("mrst_ready", cfg_ready, 1'b1);
    end
    for (int t = 0; t <= 3; t++) begin
      tick;
      chk("mrst_dflt", pat_out, (t % 2 == 0) ? 3'b100 : 3'b000);
    end
    run_en = 3'b000;
    tick;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_pattern_ctrl.md
Name: clk_pattern_ctrl

Overview:
- Synthesizable controller that generates NUM_CH independent periodic clock-pattern outputs on one system clock.
- Each channel has a programmable high time and low time, counted in clk cycles, e.g. 50% and 30/70 duty patterns.
- Replaces behavioural delay-based clock generation with cycle-accurate, runtime-reconfigurable patterns.
- Feeds clock-enable and strobe consumers, and is programmed through a valid/ready config port.

Parameters:
- NUM_CH, 3, number of pattern channels (1..4).
- CNT_W, 8, width of the high/low count fields. Maximum phase length is 2^CNT_W-1 cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; the transfer occurs on a cycle where cfg_valid && cfg_ready.
- cfg_ch  in  2  target channel index.
- cfg_high  in  CNT_W  high-phase length in cycles.
- cfg_low  in  CNT_W  low-phase length in cycles.
- cfg_err  out  1  one-cycle pulse when an accepted config is rejected.
- run_en  in  NUM_CH  per-channel run request.
- pat_out  out  NUM_CH  registered pattern outputs.
- period_start  out  NUM_CH  one-cycle pulse on the first high cycle of each period.
- busy  out  NUM_CH  channel is in the HIGH or LOW state.

Behaviour:
- Reset (rst=1 at an edge):
  - pat_out, period_start, busy, cfg_err = 0.
  - All channels enter IDLE.
  - Active config is H=1, L=1 for every channel.
  - All pending flags are cleared.
- Reset mid-period: outputs are 0 from the next edge. Pending configs are discarded.
- cfg_ready:
  - cfg_ready = !pending[cfg_ch] when cfg_ch < NUM_CH.
  - cfg_ready = 1 when cfg_ch >= NUM_CH.
  - This is combinational from cfg_ch. It is the only combinational output.
- Accepted transfer handling:
  - cfg_ch >= NUM_CH, cfg_high == 0, or cfg_low == 0: cfg_err pulses the next cycle and nothing is stored.
  - Otherwise, with the channel in IDLE: the values load directly into the active config.
  - Otherwise, with the channel not in IDLE: the values load into the shadow register and pending is set.
- Per-channel FSM, with state and a counter cnt (CNT_W bits):
  - IDLE: pat_out=0. If run_en[i] is sampled 1, go to HIGH with cnt=H-1, pat_out=1 and period_start=1 on the next cycle. Latency is 1 cycle from sampling run_en.
  - HIGH: pat_out=1. Decrement cnt. When cnt==0, go to LOW with cnt=L-1. pat_out is therefore high for exactly H cycles.
  - LOW: pat_out=0. Decrement cnt. When cnt==0, a period boundary occurs:
    - If pending is set, copy the shadow into the active config and clear pending.
    - If run_en[i] is 1, go to HIGH using the (possibly new) H, with period_start=1.
    - Otherwise go to IDLE.
- Period timing: period = H+L cycles exactly. Back-to-back periods have no gap cycle.
- run_en deassert mid-period: the current period always completes (no truncated pulses, glitch-free). The channel stops at the boundary.
- Config accepted on the same edge as that channel's boundary:
  - The boundary uses the pre-edge pending state.
  - The new config becomes pending and applies at the following boundary.
- Counters never wrap: H and L are guaranteed to be at least 1, and cnt is reloaded only at phase transitions.
- Channels are fully independent. A config to one channel never affects another.

Decomposition:
- Shared package clk_pattern_pkg holds:
  - the state typedef (IDLE, HIGH, LOW);
  - the CH_W=2 constant;
  - the reset defaults RST_HIGH=1 and RST_LOW=1.
- Sub-module clk_pattern_chan contains one channel's FSM, counter, active and shadow registers, and pending flag. It is instantiated NUM_CH times by generate.
- The top level holds config decode, cfg_ready/cfg_err generation and output concatenation.

Test Plan:
- Reset defaults: rst for 2 cycles, then run_en=3'b111 with no config. Required: every pat_out toggles every cycle (H=1, L=1), and period_start pulses every 2 cycles.
- IDLE load: program ch2 with H=3, L=7, then run_en[2]=1. Required: pat_out[2] first rises 1 cycle after run_en is sampled, then repeats 3 high / 7 low with period 10. busy[2]=1 throughout.
- Shadow config: ch0 runs H=2, L=2; write H=4, L=1 mid-HIGH.
  - The current and remaining periods up to the next boundary keep 2/2.
  - From the boundary the pattern is 4/1.
  - A second write before that boundary sees cfg_ready=0.
- Error handling: write ch1 with H=0, L=5, and separately cfg_ch=3. Required: a cfg_err pulse one cycle after each transfer, and ch1 behaviour unchanged.
- Graceful stop: ch0 running H=5, L=5; drop run_en[0] on the 2nd high cycle. Required: the period completes (3 more high cycles, 5 low), then IDLE with busy[0]=0 and no further period_start.
- Boundary collision and reset mid-operation:
  - Write a config on the exact boundary edge. Required: it applies one period later.
  - Assert rst during HIGH. Required: pat_out=0 and busy=0 on the next cycle, and cfg_ready=1 for all channels.
